// File: rtl/cdc_sync_pkg.sv
// +----------------------------------------------------------------------------+
// | cdc_sync_pkg : shared constants and helpers for cdc_sync_filter            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cdc_sync_pkg;

   localparam int C_STAGES_DEF = 2;
   localparam int C_FILTER_DEF = 4;

   // The counter never has to hold G_FILTER itself, only up to G_FILTER-1.
   function automatic int cnt_width(input int filter);
      return (filter <= 2) ? 1 : $clog2(filter);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_filter_ch.sv
// +----------------------------------------------------------------------------+
// | sync_filter_ch : one channel of synchroniser, debounce filter, edge pulses |
// | and sticky glitch flag; edge pulses built only with CDC_SYNC_EDGE_EN.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_filter_ch
   import cdc_sync_pkg::*;
#(
   parameter int   G_STAGES  = C_STAGES_DEF,
   parameter int   G_FILTER  = C_FILTER_DEF,
   parameter logic G_RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   input  logic i_glitch_clr,
   output logic o_level,
   output logic o_rise,
   output logic o_fall,
   output logic o_glitch
);

   localparam int              C_CW      = cnt_width(G_FILTER);
   localparam logic [C_CW-1:0] C_CNT_MAX = C_CW'(G_FILTER - 1);

   (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
   logic [G_STAGES-1:0] sync_q;
   logic [G_STAGES-1:0] sync_d;
   logic [C_CW-1:0]     cnt_q, cnt_d;
   logic                level_q, level_d;
   logic                glitch_q, glitch_d;
   logic                sync;

   assign sync = sync_q[G_STAGES-1];

   always_comb begin
      sync_d   = {sync_q[G_STAGES-2:0], i_async};
      level_d  = level_q;
      cnt_d    = cnt_q;
      glitch_d = glitch_q & ~i_glitch_clr;
      if (sync == level_q) begin
         cnt_d = '0;
         // A non-zero count here means the input moved and came back early.
         if (cnt_q != '0) begin
            glitch_d = 1'b1;
         end
      end else if (cnt_q == C_CNT_MAX) begin
         level_d = sync;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + C_CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q   <= {G_STAGES{G_RST_VAL}};
         level_q  <= G_RST_VAL;
         cnt_q    <= '0;
         glitch_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         level_q  <= level_d;
         cnt_q    <= cnt_d;
         glitch_q <= glitch_d;
      end
   end

   assign o_level  = level_q;
   assign o_glitch = glitch_q;

`ifdef CDC_SYNC_EDGE_EN
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   always_comb begin
      rise_d = (level_d != level_q) &&  level_d;
      fall_d = (level_d != level_q) && !level_d;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign o_rise = rise_q;
   assign o_fall = fall_q;
`else
   assign o_rise = 1'b0;
   assign o_fall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/cdc_sync_filter.sv
// +----------------------------------------------------------------------------+
// | cdc_sync_filter : multi-channel level synchroniser with debounce filter.   |
// | Channels are independent; never pass multi-bit buses. Macro: CDC_SYNC_EDGE_EN |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cdc_sync_filter
   import cdc_sync_pkg::*;
#(
   parameter int                    G_CHANNELS = 4,
   parameter int                    G_STAGES   = C_STAGES_DEF,
   parameter int                    G_FILTER   = C_FILTER_DEF,
   parameter logic [G_CHANNELS-1:0] G_RST_VAL  = '0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [G_CHANNELS-1:0] i_async,
   input  logic [G_CHANNELS-1:0] i_glitch_clr,
   output logic [G_CHANNELS-1:0] o_level,
   output logic [G_CHANNELS-1:0] o_rise,
   output logic [G_CHANNELS-1:0] o_fall,
   output logic [G_CHANNELS-1:0] o_glitch
);

   generate
      for (genvar i = 0; i < G_CHANNELS; i++) begin : g_ch
         sync_filter_ch #(
            .G_STAGES  (G_STAGES),
            .G_FILTER  (G_FILTER),
            .G_RST_VAL (G_RST_VAL[i])
         ) u_ch (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_async      (i_async[i]),
            .i_glitch_clr (i_glitch_clr[i]),
            .o_level      (o_level[i]),
            .o_rise       (o_rise[i]),
            .o_fall       (o_fall[i]),
            .o_glitch     (o_glitch[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cdc_sync_filter.sv
// +----------------------------------------------------------------------------+
// | tb_cdc_sync_filter : directed self-checking bench for cdc_sync_filter      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cdc_sync_filter;

`ifdef CDC_SYNC_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   localparam logic [3:0] RST_VAL = 4'b1010;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] async_in;
   logic [3:0] glitch_clr;
   logic [3:0] level, rise, fall, glitch;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cdc_sync_filter #(
      .G_CHANNELS (4),
      .G_STAGES   (2),
      .G_FILTER   (4),
      .G_RST_VAL  (RST_VAL)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_async      (async_in),
      .i_glitch_clr (glitch_clr),
      .o_level      (level),
      .o_rise       (rise),
      .o_fall       (fall),
      .o_glitch     (glitch)
   );

   // One active edge; returns on the following falling edge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [3:0] exp_lvl, exp_fall;
      rst = 1'b1; async_in = 4'b0000; glitch_clr = 4'b0000;
      tick(); tick();
      n_checks++;
      if ({level, rise, fall, glitch} !== {RST_VAL, 12'h000}) begin
         n_fail++;
         $display("FAIL reset_state: lvl/rise/fall/glitch=%b %b %b %b required %b 0000 0000 0000",
                  level, rise, fall, glitch, RST_VAL);
      end
      rst = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         tick();
         exp_lvl  = (c >= 6) ? 4'b0000 : RST_VAL;
         exp_fall = (c == 6 && EDGE_EN) ? 4'b1010 : 4'b0000;
         n_checks++;
         if ({level, rise, fall, glitch} !== {exp_lvl, 4'b0000, exp_fall, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_release c=%0d: lvl/rise/fall/glitch=%b %b %b %b required %b 0000 %b 0000",
                     c, level, rise, fall, glitch, exp_lvl, exp_fall);
         end
      end
   endtask

   task automatic test_rise();
      logic [3:0] exp_lvl, exp_rise;
      async_in = 4'b0001;
      for (int c = 1; c <= 8; c++) begin
         tick();
         exp_lvl  = (c >= 6) ? 4'b0001 : 4'b0000;
         exp_rise = (c == 6 && EDGE_EN) ? 4'b0001 : 4'b0000;
         n_checks++;
         if ({level, rise, fall, glitch} !== {exp_lvl, exp_rise, 4'b0000, 4'b0000}) begin
            n_fail++;
            $display("FAIL rise_ch0 c=%0d: lvl/rise/fall/glitch=%b %b %b %b required %b %b 0000 0000",
                     c, level, rise, fall, glitch, exp_lvl, exp_rise);
         end
      end
   endtask

   task automatic test_glitch();
      // Three-cycle pulse: counter reaches G_FILTER-1 exactly as the input reverts.
      async_in[2] = 1'b1;
      tick(); tick(); tick();
      async_in[2] = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         n_checks++;
         if ({level, rise, fall} !== {4'b0001, 8'h00} || glitch !== ((c >= 3) ? 4'b0100 : 4'b0000)) begin
            n_fail++;
            $display("FAIL glitch_short c=%0d: lvl/rise/fall/glitch=%b %b %b %b required 0001 0000 0000 %b",
                     c, level, rise, fall, glitch, (c >= 3) ? 4'b0100 : 4'b0000);
         end
      end
      glitch_clr[2] = 1'b1;
      tick();
      glitch_clr[2] = 1'b0;
      n_checks++;
      if (glitch !== 4'b0000) begin
         n_fail++;
         $display("FAIL glitch_clear: glitch=%b required 0000", glitch);
      end
      // One-cycle pulse; clear held on the edge that sets the flag.
      async_in[2] = 1'b1;
      tick();
      async_in[2] = 1'b0;
      tick(); tick();
      glitch_clr[2] = 1'b1;
      tick();
      n_checks++;
      if (glitch !== 4'b0100 || level !== 4'b0001) begin
         n_fail++;
         $display("FAIL glitch_set_wins: glitch=%b lvl=%b required 0100 0001", glitch, level);
      end
      tick();
      glitch_clr[2] = 1'b0;
      n_checks++;
      if (glitch !== 4'b0000) begin
         n_fail++;
         $display("FAIL glitch_clear2: glitch=%b required 0000", glitch);
      end
   endtask

   task automatic test_back_to_back();
      logic       lvl0, exp_r, exp_f;
      int         n, n_rise, n_fall;
      lvl0 = 1'b1; n_rise = 0; n_fall = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c <= 29 && (c % 4) == 1) async_in[0] = ~async_in[0];
         tick();
         n     = (c >= 6) ? ((c - 6) / 4 + 1) : 0;
         exp_r = 1'b0; exp_f = 1'b0;
         if (c >= 6 && c <= 34 && ((c - 6) % 4) == 0) begin
            lvl0  = ~lvl0;
            exp_r = EDGE_EN &  lvl0;
            exp_f = EDGE_EN & ~lvl0;
         end
         if (n > 8) n = 8;
         n_checks++;
         if ({level, rise, fall, glitch} !== {3'b000, lvl0, 3'b000, exp_r, 3'b000, exp_f, 4'b0000}) begin
            n_fail++;
            $display("FAIL b2b c=%0d: lvl/rise/fall/glitch=%b %b %b %b required %b %b %b 0000",
                     c, level, rise, fall, glitch, {3'b000, lvl0}, {3'b000, exp_r}, {3'b000, exp_f});
         end
         if (rise[0]) n_rise++;
         if (fall[0]) n_fall++;
      end
      n_checks++;
      if (n_rise != (EDGE_EN ? 4 : 0) || n_fall != (EDGE_EN ? 4 : 0)) begin
         n_fail++;
         $display("FAIL b2b_pulse_count: rise=%0d fall=%0d required %0d each", n_rise, n_fall, EDGE_EN ? 4 : 0);
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] exp_lvl, exp_fall;
      async_in = 4'b0011;
      tick(); tick(); tick(); tick();
      async_in = 4'b0000;
      rst      = 1'b1;
      tick();
      rst      = 1'b0;
      n_checks++;
      if ({level, rise, fall, glitch} !== {RST_VAL, 12'h000}) begin
         n_fail++;
         $display("FAIL reset_mid: lvl/rise/fall/glitch=%b %b %b %b required %b 0000 0000 0000",
                  level, rise, fall, glitch, RST_VAL);
      end
      for (int c = 1; c <= 8; c++) begin
         tick();
         exp_lvl  = (c >= 6) ? 4'b0000 : RST_VAL;
         exp_fall = (c == 6 && EDGE_EN) ? 4'b1010 : 4'b0000;
         n_checks++;
         if ({level, rise, fall, glitch} !== {exp_lvl, 4'b0000, exp_fall, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_mid_restart c=%0d: lvl/rise/fall/glitch=%b %b %b %b required %b 0000 %b 0000",
                     c, level, rise, fall, glitch, exp_lvl, exp_fall);
         end
      end
   endtask

   initial begin
      rst = 1'b1; async_in = 4'b0000; glitch_clr = 4'b0000;
      @(negedge clk);
      test_reset();
      test_rise();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cdc_sync_filter.md
# cdc_sync_filter

Multi-channel asynchronous-input synchroniser with per-channel debounce filtering, edge-event pulses and a sticky glitch flag. Each channel brings one asynchronous level signal into the i_clk domain through a G_STAGES flop chain, then only accepts a new level once it has been stable for G_FILTER consecutive cycles. It sits at the boundary of every block that samples off-chip or cross-domain quasi-static levels, such as straps, buttons, status lines and handshake levels, and replaces ad-hoc per-signal synchroniser instances.

## Interface
Parameters:
- G_CHANNELS, 4: number of independent channels (≥1)
- G_STAGES, 2: synchroniser flop stages per channel (≥2)
- G_FILTER, 4: consecutive stable cycles required before o_level changes (≥1; 1 = plain register)
- G_RST_VAL, '0 (G_CHANNELS bits): per-channel reset level of sync chain and o_level

Ports:
- i_clk  in  1  destination clock
- i_rst  in  1  reset, synchronous, active-high
- i_async  in  G_CHANNELS  asynchronous level inputs
- i_glitch_clr  in  G_CHANNELS  per-channel clear of o_glitch
- o_level  out  G_CHANNELS  filtered, synchronised level
- o_rise  out  G_CHANNELS  one-cycle pulse on o_level 0→1
- o_fall  out  G_CHANNELS  one-cycle pulse on o_level 1→0
- o_glitch  out  G_CHANNELS  sticky: synced input toggled and reverted before filter expiry

## Operation
- Per channel i: shift chain s[0..G_STAGES-1]; s[0] <= i_async[i]; sync = s[G_STAGES-1].
- Filter counter cnt, width $clog2(G_FILTER) (min 1 bit), saturates by construction at G_FILTER-1.
- If sync == o_level: cnt <= 0. If cnt != 0 in that cycle, o_glitch[i] <= 1.
- If sync != o_level and cnt == G_FILTER-1: o_level <= sync, cnt <= 0, and o_rise or o_fall (by new value) <= 1.
- If sync != o_level otherwise: cnt <= cnt+1.
- o_rise/o_fall are registered and asserted in the same cycle o_level shows the new value. They are low in every other cycle, never both high, and never asserted as a result of reset.
- o_glitch: set as above, cleared by i_glitch_clr[i]. Simultaneous set and clear: set wins.
- Channels are fully independent. There is no cross-channel coherency: multi-bit buses must not be passed through this block.

## Timing
- Reset (i_rst=1 at a clock edge): s[*] <= G_RST_VAL[i], o_level <= G_RST_VAL, cnt <= 0, o_rise = o_fall = 0, o_glitch = 0. Reset takes priority over all other updates.
- Reset mid-filter: partial count is discarded, with no pulse and no glitch flag. After release, filtering restarts from G_RST_VAL.
- Latency: an i_async change held stable from before edge k appears at sync after edge k+G_STAGES-1. o_level changes after edge k+G_STAGES+G_FILTER-1, so G_STAGES+G_FILTER edges in total.
- Minimum accepted pulse width at sync: G_FILTER cycles. Shorter excursions produce o_glitch and no o_level change.
- Input toggling back to o_level exactly at the cycle cnt reaches G_FILTER-1: this is a glitch, not a change.
- Back-to-back accepted changes are possible every G_FILTER cycles. Their pulses never merge.

## Configuration
- CDC_SYNC_EDGE_EN defined: o_rise/o_fall generated as specified.
- CDC_SYNC_EDGE_EN undefined: o_rise and o_fall tied to '0, and their registers are not synthesised. o_level and o_glitch behaviour is unchanged.

## Structure
- Package cdc_sync_pkg: function cnt_width(G_FILTER) returning max(1,$clog2(G_FILTER)), plus the default constants for G_STAGES and G_FILTER.
- Sub-module sync_filter_ch holds one channel: chain, counter, level, pulses and glitch flag. The top level is a generate loop over G_CHANNELS.
- Sync chain flops carry the ASYNC_REG attribute with SHREG_EXTRACT = "NO".

## Test plan
- Reset with G_RST_VAL=4'b1010 and i_async=0 → o_level=1010, pulses 0, o_glitch 0. After release with i_async=0 held, ch1/ch3 fall after G_STAGES+G_FILTER = 6 edges, each with one o_fall pulse.
- Defaults, ch0 i_async 0→1 held → o_level[0] rises on edge 6 with a single-cycle o_rise[0]. Other channels stay quiet.
- ch2 high pulse of 3 cycles (G_FILTER=4) → o_level[2] unchanged, o_glitch[2]=1 until i_glitch_clr[2]. Applying clear on the same cycle as a new glitch → o_glitch stays 1.
- Toggle ch0 every 4 cycles for 32 cycles → o_level follows with 4-cycle spacing, and 8 alternating rise/fall pulses with no overlap.
- Assert i_rst while cnt=2 on ch1 → no pulse, o_level=G_RST_VAL, cnt=0. The filter restarts cleanly after release.
- Build without CDC_SYNC_EDGE_EN and rerun scenario 2 → o_rise/o_fall constant 0, o_level timing identical.
